// File: rtl/dpram_arbiter.sv
// Dual-port RAM arbiter: post-reset clear sweep, then independent round-robin write/read grants.
// Optional same-cycle write-to-read forwarding is built when DPRAM_ARB_BYPASS_EN is defined.
module dpram_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_reqValid,
  input  logic [1:0]            i_reqWe,
  input  logic [ADDR_WIDTH-1:0] i_reqAddr0,
  input  logic [ADDR_WIDTH-1:0] i_reqAddr1,
  input  logic [XLEN-1:0]       i_reqData0,
  input  logic [XLEN-1:0]       i_reqData1,
  output logic [1:0]            o_reqReady,
  output logic [1:0]            o_rspValid,
  output logic [XLEN-1:0]       o_rspData,
  output logic                  o_busy,
  output logic                  o_ramWe,
  output logic [ADDR_WIDTH-1:0] o_ramWAddr,
  output logic [ADDR_WIDTH-1:0] o_ramRAddr,
  output logic [XLEN-1:0]       o_ramDataIn,
  input  logic [XLEN-1:0]       i_ramQ
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [ADDR_WIDTH-1:0] raddr_q;

  logic                  run;
  logic [1:0]            wr_req, rd_req, wr_gnt, rd_gnt;
  logic                  wr_sel, rd_sel;
  logic [ADDR_WIDTH-1:0] wr_addr_p0, rd_addr_p0;
  logic [XLEN-1:0]       wr_data_p0;

  logic                  rsp_vld_p1;
  logic                  rsp_id_p1;

  // Arbitration is gated by reset so no grant is seen while i_rst is high.
  always_comb begin
    run    = (state == RUN) && !i_rst;
    wr_req = i_reqValid & i_reqWe & {2{run}};
    rd_req = i_reqValid & ~i_reqWe & {2{run}};
    wr_gnt = (wr_req == 2'b11) ? (wr_ptr ? 2'b10 : 2'b01) : wr_req;
    rd_gnt = (rd_req == 2'b11) ? (rd_ptr ? 2'b10 : 2'b01) : rd_req;
    wr_sel = wr_gnt[1];
    rd_sel = rd_gnt[1];
    wr_addr_p0 = wr_sel ? i_reqAddr1 : i_reqAddr0;
    wr_data_p0 = wr_sel ? i_reqData1 : i_reqData0;
    rd_addr_p0 = rd_sel ? i_reqAddr1 : i_reqAddr0;
  end

  assign o_reqReady  = wr_gnt | rd_gnt;
  assign o_busy      = (state == CLEAR);
  assign o_ramWe     = (state == CLEAR) ? !i_rst : (|wr_gnt);
  assign o_ramWAddr  = (state == CLEAR) ? clr_cnt : wr_addr_p0;
  assign o_ramDataIn = (state == CLEAR) ? '0 : wr_data_p0;
  assign o_ramRAddr  = (|rd_gnt) ? rd_addr_p0 : raddr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      raddr_q    <= '0;
      rsp_vld_p1 <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_WIDTH{1'b1}})
          state <= RUN;
      end
      // A contested grant hands priority to the loser.
      if (wr_req == 2'b11)
        wr_ptr <= ~wr_ptr;
      if (rd_req == 2'b11)
        rd_ptr <= ~rd_ptr;
      if (|rd_gnt)
        raddr_q <= rd_addr_p0;
      rsp_vld_p1 <= |rd_gnt;
    end
  end

  // ---- stage p0 -> p1: read response bookkeeping ----
  always_ff @(posedge i_clk) begin
    rsp_id_p1 <= rd_sel;
  end

  assign o_rspValid = (rsp_vld_p1 && !i_rst) ? (rsp_id_p1 ? 2'b10 : 2'b01) : 2'b00;

`ifdef DPRAM_ARB_BYPASS_EN
  logic            byp_hit_p1;
  logic [XLEN-1:0] byp_data_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      byp_hit_p1 <= 1'b0;
    else
      byp_hit_p1 <= (|wr_gnt) && (|rd_gnt) && (wr_addr_p0 == rd_addr_p0);
  end

  always_ff @(posedge i_clk) begin
    byp_data_p1 <= wr_data_p0;
  end

  assign o_rspData = byp_hit_p1 ? byp_data_p1 : i_ramQ;
`else
  assign o_rspData = i_ramQ;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural 1-cycle-latency dual-port RAM.
module tb_dpram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [4:0]  req_addr0, req_addr1;
  logic [31:0] req_data0, req_data1;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, ram_we;
  logic [4:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_din, ram_q;

  logic [31:0] mem [0:31];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_byp;

  always #5 clk = ~clk;

  dpram_arbiter #(.XLEN(32), .ADDR_WIDTH(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_reqValid(req_valid), .i_reqWe(req_we),
    .i_reqAddr0(req_addr0), .i_reqAddr1(req_addr1),
    .i_reqData0(req_data0), .i_reqData1(req_data1),
    .o_reqReady(req_ready), .o_rspValid(rsp_valid), .o_rspData(rsp_data),
    .o_busy(busy), .o_ramWe(ram_we), .o_ramWAddr(ram_waddr),
    .o_ramRAddr(ram_raddr), .o_ramDataIn(ram_din), .i_ramQ(ram_q)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    ram_q <= mem[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v; req_we = we;
    req_addr0 = a0; req_data0 = d0;
    req_addr1 = a1; req_data1 = d1;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk); rst = 1'b0; #1;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_we"}, 32'(ram_we), 32'd1);
      check({tag, "_waddr"}, 32'(ram_waddr), 32'(k));
      check({tag, "_din"}, ram_din, 32'd0);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
    end
  endtask

  initial begin
`ifdef DPRAM_ARB_BYPASS_EN
    exp_byp = 32'hDEADBEEF;
`else
    exp_byp = 32'h0;
`endif
    rst = 1'b1;
    drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Reset held: after first reset edge
    @(negedge clk); #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);

    // Sweep with both requesters already waiting to write
    drive(2'b11, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
    sweep("sw1");

    @(negedge clk); #1;
    check("wr0_busy", 32'(busy), 32'd0);
    check("wr0_ready", 32'(req_ready), 32'b01);
    check("wr0_we", 32'(ram_we), 32'd1);
    check("wr0_waddr", 32'(ram_waddr), 32'd3);
    check("wr0_din", ram_din, 32'h11);
    @(negedge clk); #1;
    check("wr1_ready", 32'(req_ready), 32'b10);
    check("wr1_waddr", 32'(ram_waddr), 32'd4);
    check("wr1_din", ram_din, 32'h22);
    @(negedge clk); drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); #1;
    check("idle_ready", 32'(req_ready), 32'd0);
    check("idle_we", 32'(ram_we), 32'd0);
    @(negedge clk); drive(2'b11, 2'b11, 5'd6, 32'h66, 5'd7, 32'h77); #1;
    check("wr2_ready", 32'(req_ready), 32'b01);
    check("wr2_waddr", 32'(ram_waddr), 32'd6);

    // Write/read collision on addr 5
    @(negedge clk); drive(2'b11, 2'b01, 5'd5, 32'hDEADBEEF, 5'd5, 32'h0); #1;
    check("col_ready", 32'(req_ready), 32'b11);
    check("col_we", 32'(ram_we), 32'd1);
    check("col_waddr", 32'(ram_waddr), 32'd5);
    check("col_raddr", 32'(ram_raddr), 32'd5);
    @(negedge clk); drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); #1;
    check("col_rspv", 32'(rsp_valid), 32'b10);
    check("col_rspd", rsp_data, exp_byp);
    @(negedge clk); #1;
    check("col_rspv_off", 32'(rsp_valid), 32'd0);

    // Contested back-to-back reads
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) drive(2'b11, 2'b00, 5'd3, 32'h0, 5'd4, 32'h0);
      else       drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      if (i < 6) begin
        check($sformatf("rd%0d_ready", i), 32'(req_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
        check($sformatf("rd%0d_raddr", i), 32'(ram_raddr), (i % 2 == 0) ? 32'd3 : 32'd4);
      end else begin
        check("rd_hold_raddr", 32'(ram_raddr), 32'd4);
      end
      if (i > 0) begin
        check($sformatf("rd%0d_rspv", i), 32'(rsp_valid), (i % 2 == 1) ? 32'b01 : 32'b10);
        check($sformatf("rd%0d_rspd", i), rsp_data, (i % 2 == 1) ? 32'h11 : 32'h22);
      end
    end

    // Reset right after a granted read
    @(negedge clk); drive(2'b01, 2'b00, 5'd3, 32'h0, 5'd0, 32'h0); #1;
    check("rr_ready", 32'(req_ready), 32'b01);
    @(negedge clk); rst = 1'b1; #1;
    check("rr_rspv", 32'(rsp_valid), 32'd0);
    check("rr_ready_rst", 32'(req_ready), 32'd0);
    check("rr_we_rst", 32'(ram_we), 32'd0);
    sweep("sw2");
    @(negedge clk); #1;
    check("rr2_busy", 32'(busy), 32'd0);
    check("rr2_ready", 32'(req_ready), 32'b01);
    check("rr2_raddr", 32'(ram_raddr), 32'd3);
    @(negedge clk); drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); #1;
    check("rr2_rspv", 32'(rsp_valid), 32'b01);
    check("rr2_rspd", rsp_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
